// File: rtl/mov_sum100.sv
// mov_sum100: moving-window sum of the last DEPTH signed samples.
// Valid/ready in and out, single result register, no skid buffer.
// Ports:
//   clk, rst (async, active-low), clr (sync clear)
//   in[W-1:0], in_valid, in_ready  : sample input
//   out_sum[W+6:0], out_valid, out_ready, out_full : result output
//   tap[W-1:0]   : sample leaving the window (only with MOV_SUM_TAP_EN)
module mov_sum100 #(
  parameter int DEPTH = 100,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W+6:0] out_sum,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef MOV_SUM_TAP_EN
  output logic [W-1:0] tap,
`endif
  output logic         out_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [W-1:0]  r_buf [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [FW-1:0] r_fill;
`ifdef MOV_SUM_TAP_EN
  logic [W-1:0]  r_tap;
`endif

  logic          w_acc;
  logic          w_xfer;
  logic          w_is_full;
  logic [W-1:0]  w_old;
  logic [W+6:0]  w_next;

  assign in_ready  = !out_valid || out_ready;
  assign w_acc     = in_valid && in_ready && !clr;
  assign w_xfer    = out_valid && out_ready;
  assign w_is_full = (r_fill == FULL);

  // Slots not yet written since reset/clr are masked out here,
  // so the buffer itself never needs clearing.
  assign w_old  = w_is_full ? r_buf[r_wptr] : '0;
  assign w_next = out_sum
                + {{7{in[W-1]}}, in}
                - {{7{w_old[W-1]}}, w_old};

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[r_wptr] <= in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_fill    <= '0;
      out_sum   <= '0;
      out_full  <= 1'b0;
      out_valid <= 1'b0;
`ifdef MOV_SUM_TAP_EN
      r_tap     <= '0;
`endif
    end else if (clr) begin
      r_wptr    <= '0;
      r_fill    <= '0;
      out_sum   <= '0;
      out_full  <= 1'b0;
      out_valid <= 1'b0;
`ifdef MOV_SUM_TAP_EN
      r_tap     <= '0;
`endif
    end else if (w_acc) begin
      r_wptr    <= (r_wptr == LAST) ? '0 : r_wptr + AW'(1);
      if (!w_is_full) r_fill <= r_fill + FW'(1);
      out_sum   <= w_next;
      // full after this accept: already full, or this is sample DEPTH
      out_full  <= (r_fill >= FULL - FW'(1));
      out_valid <= 1'b1;
`ifdef MOV_SUM_TAP_EN
      r_tap     <= w_old;
`endif
    end else if (w_xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MOV_SUM_TAP_EN
  assign tap = r_tap;
`endif

endmodule

// File: tb/tb_mov_sum100.sv
// tb_mov_sum100: randomized and directed checks of mov_sum100
// against a queue-based window model.
module tb_mov_sum100;

  localparam int DEPTH = 100;
  localparam int W     = 32;

  logic         clk;
  logic         rst;
  logic         clr;
  logic [W-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W+6:0] out_sum;
  logic         out_valid;
  logic         out_ready;
  logic         out_full;
`ifdef MOV_SUM_TAP_EN
  logic [W-1:0] tap;
`endif

  mov_sum100 #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef MOV_SUM_TAP_EN
    .tap      (tap),
`endif
    .out_full (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  longint hist[$];
  bit     m_valid;
  longint m_sum;
  bit     m_full;
  longint m_tap;
  bit     obs_rdy;
  bit     exp_rdy;

  function automatic longint sv(input logic [W-1:0] d);
    return longint'($signed(d));
  endfunction

  function automatic longint obs_sum();
    return longint'($signed(out_sum));
  endfunction

  task automatic model_clear();
    hist.delete();
    m_valid = 0;
    m_sum   = 0;
    m_full  = 0;
    m_tap   = 0;
  endtask

  // drive one cycle from posedge+1, return at next posedge+1
  task automatic step(input bit v, input logic [W-1:0] d,
                      input bit ordy, input bit c);
    bit acc;
    longint old;
    in_valid  = v;
    in        = d;
    out_ready = ordy;
    clr       = c;
    exp_rdy   = !m_valid || ordy;
    #1;
    obs_rdy   = in_ready;
    acc       = v && exp_rdy && !c;
    @(posedge clk);
    #1;
    in_valid = 0;
    clr      = 0;
    if (c) begin
      model_clear();
    end else if (acc) begin
      old = (hist.size() == DEPTH) ? hist[0] : 0;
      hist.push_back(sv(d));
      if (hist.size() > DEPTH) void'(hist.pop_front());
      m_sum = 0;
      foreach (hist[i]) m_sum += hist[i];
      m_full  = (hist.size() == DEPTH);
      m_tap   = old;
      m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 ||
        out_full !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset: v=%b s=%0d f=%b r=%b req 0/0/0/1",
               out_valid, obs_sum(), out_full, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_clear();
  endtask

  task automatic test_ones();
    for (int i = 1; i <= 150; i++) begin
      step(1, 1, 1, 0);
      n_checks++;
      if (obs_sum() !== longint'((i < DEPTH) ? i : DEPTH) ||
          out_full !== (i >= DEPTH) || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL ones[%0d]: s=%0d f=%b v=%b req s=%0d f=%b v=1",
                 i, obs_sum(), out_full, out_valid,
                 (i < DEPTH) ? i : DEPTH, i >= DEPTH);
      end
    end
  endtask

  task automatic test_ramp();
    step(0, 0, 1, 1);
    for (int i = 0; i < 200; i++) begin
      step(1, i, 1, 0);
      n_checks++;
      if (obs_sum() !== m_sum || out_full !== m_full) begin
        n_errors++;
        $display("FAIL ramp[%0d]: s=%0d f=%b req s=%0d f=%b",
                 i, obs_sum(), out_full, m_sum, m_full);
      end
      if (i == 99 || i == 199) begin
        n_checks++;
        if (obs_sum() !== ((i == 99) ? 64'sd4950 : 64'sd14950)) begin
          n_errors++;
          $display("FAIL ramp_const[%0d]: s=%0d", i, obs_sum());
        end
      end
`ifdef MOV_SUM_TAP_EN
      if (i == 199) begin
        n_checks++;
        if (tap !== 32'd99) begin
          n_errors++;
          $display("FAIL ramp_tap: tap=%0d req 99", tap);
        end
      end
`endif
    end
  endtask

  task automatic test_min();
    step(0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 32'h8000_0000, 1, 0);
    n_checks++;
    if (obs_sum() !== -64'sd214748364800 || out_full !== 1'b1) begin
      n_errors++;
      $display("FAIL min_full: s=%0d f=%b req -214748364800 f=1",
               obs_sum(), out_full);
    end
    step(1, 0, 1, 0);
    n_checks++;
    if (obs_sum() !== -64'sd212600881152) begin
      n_errors++;
      $display("FAIL min_zero: s=%0d req -212600881152", obs_sum());
    end
  endtask

  task automatic test_stall();
    longint held;
    step(1, 32'd11, 1, 0);
    held = m_sum;
    for (int k = 0; k < 5; k++) begin
      step(1, 32'd22, 0, 0);
      n_checks++;
      if (obs_rdy !== 1'b0 || obs_sum() !== held ||
          out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL stall[%0d]: rdy=%b s=%0d v=%b req 0 %0d 1",
                 k, obs_rdy, obs_sum(), out_valid, held);
      end
    end
    step(1, 32'd22, 1, 0);
    n_checks++;
    if (obs_rdy !== 1'b1 || obs_sum() !== m_sum ||
        obs_sum() !== held + 22 - (m_full ? m_tap : 0)) begin
      n_errors++;
      $display("FAIL stall_release: s=%0d req %0d", obs_sum(), m_sum);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
      n_checks++;
      if (obs_rdy !== exp_rdy || out_valid !== m_valid ||
          obs_sum() !== m_sum || out_full !== m_full) begin
        n_errors++;
        $display("FAIL random[%0d]: r=%b v=%b s=%0d f=%b req %b %b %0d %b",
                 k, obs_rdy, out_valid, obs_sum(), out_full,
                 exp_rdy, m_valid, m_sum, m_full);
      end
`ifdef MOV_SUM_TAP_EN
      n_checks++;
      if (sv(tap) !== m_tap) begin
        n_errors++;
        $display("FAIL random_tap[%0d]: tap=%0d req %0d",
                 k, sv(tap), m_tap);
      end
`endif
    end
  endtask

  task automatic test_clr();
    step(0, 0, 1, 1);
    for (int i = 0; i < 120; i++) step(1, $urandom, 1, 0);
    step(1, 32'd55, 1, 1);
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_full !== 1'b0) begin
      n_errors++;
      $display("FAIL clr: v=%b s=%0d f=%b req 0 0 0",
               out_valid, obs_sum(), out_full);
    end
    step(1, 32'd7, 1, 0);
    n_checks++;
    if (obs_sum() !== 64'sd7 || out_full !== 1'b0 ||
        out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_next: s=%0d f=%b v=%b req 7 0 1",
               obs_sum(), out_full, out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 110; i++) step(1, $urandom, 0, 0);
    #3;
    rst = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 ||
        out_full !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset: v=%b s=%0d f=%b r=%b req 0/0/0/1",
               out_valid, obs_sum(), out_full, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_clear();
    step(1, 32'hFFFF_FFFD, 1, 0);
    n_checks++;
    if (obs_sum() !== -64'sd3 || out_full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first: s=%0d f=%b req -3 0",
               obs_sum(), out_full);
    end
  endtask

  initial begin
    rst       = 0;
    clr       = 0;
    in        = '0;
    in_valid  = 0;
    out_ready = 0;
    model_clear();
    test_reset();
    test_ones();
    test_ramp();
    test_min();
    test_stall();
    test_random();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mov_sum100.md
MOV_SUM100 -- requirements
Module: mov_sum100

Interface
REQ-001 Parameter DEPTH, default 100, window length in samples; legal range 2..128.
REQ-002 Parameter W, default 32, sample width; signed two's complement.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous window clear, active-high.
REQ-006 in  input  W  input sample.
REQ-007 in_valid  input  1  in carries a sample.
REQ-008 in_ready  output  1  block accepts in this cycle.
REQ-009 out_sum  output  W+7  signed sum of the last min(n, DEPTH) accepted samples.
REQ-010 out_valid  output  1  out_sum holds an unconsumed result.
REQ-011 out_ready  input  1  downstream takes out_sum this cycle.
REQ-012 out_full  output  1  window holds DEPTH samples; qualified by out_valid.

Function
REQ-013 A sample is accepted on a rising edge with in_valid=1 and in_ready=1; an output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-014 in_ready = !out_valid || out_ready (combinational; no skid buffer).
REQ-015 Sample storage is a DEPTH-entry circular buffer with write pointer wptr; wptr wraps from DEPTH-1 to 0 and advances by one per accepted sample.
REQ-016 Fill count fill saturates at DEPTH and increments by one per accepted sample while below DEPTH.
REQ-017 On accept: old = buf[wptr] if fill==DEPTH, else 0; buf[wptr] <= in; sum <= sum + sext(in) - sext(old), computed at W+7 bits with no overflow possible.
REQ-018 Latency: out_sum and out_valid update on the same edge that accepts the sample; out_valid=1 from the cycle after acceptance.
REQ-019 out_full on each result = 1 when the window held DEPTH samples after that accept (first at the DEPTH-th sample).
REQ-020 While out_valid=1 and out_ready=0, out_sum, out_full and out_valid hold stable and no sample is accepted.
REQ-021 An output transfer with no simultaneous accept clears out_valid on that edge; a simultaneous transfer and accept keeps out_valid=1 with the new result.
REQ-022 clr=1 on an edge: sum, fill, wptr, out_sum, out_full, out_valid -> 0; any in presented that cycle is dropped; clr has priority over accept and transfer.
REQ-023 Buffer contents are never cleared; the fill mask (REQ-017) makes stale entries invisible after reset or clr.

Reset
REQ-024 rst=0 immediately forces out_sum=0, out_valid=0, out_full=0, sum=0, fill=0, wptr=0, independent of clk.
REQ-025 in_ready=1 during and after reset (follows REQ-014).
REQ-026 Reset mid-stream discards the window and any pending output; the first sample after release yields out_sum = that sample.

Configuration
REQ-027 Macro MOV_SUM_TAP_EN: when defined, output port tap (W bits) is present and carries the registered old value of REQ-017 for the current result (0 while not full), updated and held with out_sum.
REQ-028 Without MOV_SUM_TAP_EN, the port tap and its register are absent; all other behaviour is identical.

Verification
REQ-029 Assert rst=0 mid-cycle -> out_valid=0, out_sum=0, out_full=0, in_ready=1 immediately, without a clock edge.
REQ-030 150 samples of value 1, out_ready=1 -> out_sum 1,2,...,100 then 100 constant; out_full first 1 on result 100.
REQ-031 Ramp 0..199, out_ready=1 -> result for sample 199 = 14950 (sum 100..199); result for sample 99 = 4950; with MOV_SUM_TAP_EN tap=99 at sample 199.
REQ-032 100 samples of -2^31 -> out_sum = -214748364800 with no wrap; then one sample of 0 -> -212600881152.
REQ-033 out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, out_sum stable; release -> next results continue with no lost or duplicated sample.
REQ-034 clr=1 and in_valid=1 together after 120 samples -> out_valid=0, sample dropped; next sample 7 -> out_sum=7, out_full=0.
